// File: rtl/sccb_slave_regs.sv
// SCCB/I2C slave exposing a 256-byte register file with read-only ID registers at 0x0A/0x0B.
// Bus lines are oversampled on iCLK; SDA is only ever pulled low or released.
module sccb_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter logic [7:0] PID_VAL  = 8'h76,
    parameter logic [7:0] VER_VAL  = 8'h73
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata
);

    typedef enum logic [3:0] {
        StIdle, StDevAdr, StDevAck, StSubAdr, StSubAck,
        StWrData, StWrAck, StRdData, StRdAck, StIgnore
    } state_e;

    state_e     state_q;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_dly_q, sda_dly_q;
    logic       sda_oe_q;
    logic [2:0] cnt_q;
    logic [6:0] sh_q;
    logic       rw_q;
    logic [7:0] ptr_q;
    logic       wr_valid_q, busy_q;
    logic [7:0] wr_addr_q, wr_data_q;
    logic [7:0] regs_q [256];

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in, rd_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
    assign byte_in   = {sh_q, sda_s};

    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

    always_comb begin
        rd_byte = regs_q[ptr_q];
        if (ptr_q == 8'h0A) rd_byte = PID_VAL;
        if (ptr_q == 8'h0B) rd_byte = VER_VAL;
    end

    always_comb begin
        host_rdata = regs_q[host_addr];
        if (host_addr == 8'h0A) host_rdata = PID_VAL;
        if (host_addr == 8'h0B) host_rdata = VER_VAL;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            // Synchronizers reset to the idle-high bus level so no false edges appear.
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
            state_q    <= StIdle;
            sda_oe_q   <= 1'b0;
            cnt_q      <= 3'd0;
            sh_q       <= 7'd0;
            rw_q       <= 1'b0;
            ptr_q      <= 8'h00;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I2C_SCLK};
            sda_sync_q <= {sda_sync_q[0], I2C_SDAT};
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
            wr_valid_q <= 1'b0;
            if (start_det) begin
                state_q  <= StDevAdr;
                cnt_q    <= 3'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b1;
            end else if (stop_det) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StDevAdr, StSubAdr, StWrData: begin
                        if (scl_rise) begin
                            sh_q  <= byte_in[6:0];
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                if (state_q == StDevAdr) begin
                                    rw_q    <= byte_in[0];
                                    state_q <= (byte_in[7:1] == DEV_ADDR) ? StDevAck : StIgnore;
                                end else if (state_q == StSubAdr) begin
                                    ptr_q   <= byte_in;
                                    state_q <= StSubAck;
                                end else begin
                                    if (ptr_q != 8'h0A && ptr_q != 8'h0B) begin
                                        regs_q[ptr_q] <= byte_in;
                                        wr_valid_q    <= 1'b1;
                                        wr_addr_q     <= ptr_q;
                                        wr_data_q     <= byte_in;
                                    end
                                    ptr_q   <= ptr_q + 8'd1;
                                    state_q <= StWrAck;
                                end
                            end
                        end
                    end
                    // First fall after the 8th bit asserts ACK, the second ends it.
                    StDevAck, StSubAck, StWrAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                cnt_q    <= 3'd0;
                                sda_oe_q <= 1'b0;
                                if (state_q == StDevAck && rw_q) begin
                                    state_q  <= StRdData;
                                    sda_oe_q <= ~rd_byte[7];
                                end else if (state_q == StDevAck) begin
                                    state_q <= StSubAdr;
                                end else begin
                                    state_q <= StWrData;
                                end
                            end
                        end
                    end
                    // cnt_q counts bits already sampled by the master.
                    StRdData: begin
                        if (scl_fall) sda_oe_q <= ~rd_byte[~cnt_q];
                        if (scl_rise) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) state_q <= StRdAck;
                        end
                    end
                    StRdAck: begin
                        if (scl_fall) sda_oe_q <= 1'b0;
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr_q   <= ptr_q + 8'd1;
                                cnt_q   <= 3'd0;
                                state_q <= StRdData;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

endmodule
